// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per requester (CPU, panel).
//   req   : access request, held until ack
//   we    : 1 = write, 0 = read
//   addr  : access address
//   wdata : write data
//   rdata : read data, valid with ack and held until the next ack of this requester
//   ack   : one-cycle completion pulse
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter and access sequencer: shares one memory between the
// CPU datapath and the front-panel loader, one access at a time.
//   clk, rst     : clock, synchronous active-high reset
//   cpu, pnl     : requester buses (slave side); panel requests count only with pnl_en
//   pnl_en       : panel access enable
//   mem_addr     : latched access address
//   mem_wdata    : latched write data
//   mem_rdata    : memory read data, captured at the end of a read access
//   mem_read/write : registered strobes, high for every ACCESS cycle
//   busy         : high in ACCESS and ACK
//   owner        : current or last grantee (0 = CPU, 1 = panel)
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      pnl,
    input  logic              pnl_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              busy,
    output logic              owner
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] pnl_rdata_q, pnl_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              pnl_ack_q, pnl_ack_d;

    logic              cpu_elig_c;
    logic              pnl_elig_c;
    logic              grant_pnl_c;

    // Next-state, arbitration and registered-output precompute
    always_comb begin
        cpu_elig_c  = cpu.req;
        pnl_elig_c  = pnl.req & pnl_en;
        // Panel wins if it is alone, or on a tie when the CPU was granted last
        grant_pnl_c = pnl_elig_c & (~cpu_elig_c | ~last_q);

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        pnl_rdata_d = pnl_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_elig_c || pnl_elig_c) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    last_d  = grant_pnl_c;
                    owner_d = grant_pnl_c;
                    if (grant_pnl_c) begin
                        we_d        = pnl.we;
                        mem_addr_d  = pnl.addr;
                        mem_wdata_d = pnl.wdata;
                    end else begin
                        we_d        = cpu.we;
                        mem_addr_d  = cpu.addr;
                        mem_wdata_d = cpu.wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    // Read data is taken on the edge that ends the strobe window
                    if (!we_q) begin
                        if (owner_q) pnl_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: derive them from the state being entered
        mem_read_d  = (state_d == ACCESS) & ~we_d;
        mem_write_d = (state_d == ACCESS) & we_d;
        busy_d      = (state_d != IDLE);
        cpu_ack_d   = (state_d == ACK) & ~owner_d;
        pnl_ack_d   = (state_d == ACK) & owner_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            pnl_rdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pnl_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_rdata_q <= pnl_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            pnl_ack_q   <= pnl_ack_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign cpu.rdata = cpu_rdata_q;
    assign cpu.ack   = cpu_ack_q;
    assign pnl.rdata = pnl_rdata_q;
    assign pnl.ack   = pnl_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (WAIT_CYCLES = 2 and 3) run side by side,
// each against an access-timeline model (age of the current access since grant).
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic clk;
    logic rst;

    // Per instance d (0: W=2, 1: W=3), per requester p (0: CPU, 1: panel)
    logic              req_i   [2][2];
    logic              we_i    [2][2];
    logic [ADDR_W-1:0] addr_i  [2][2];
    logic [DATA_W-1:0] wdata_i [2][2];
    logic [DATA_W-1:0] rdata_o [2][2];
    logic              ack_o   [2][2];
    logic              pnl_en_i    [2];
    logic [DATA_W-1:0] mem_rdata_i [2];
    logic [ADDR_W-1:0] mem_addr_o  [2];
    logic [DATA_W-1:0] mem_wdata_o [2];
    logic              mem_read_o  [2];
    logic              mem_write_o [2];
    logic              busy_o      [2];
    logic              owner_o     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
        mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pnl_if ();

        assign cpu_if.req   = req_i[g][0];
        assign cpu_if.we    = we_i[g][0];
        assign cpu_if.addr  = addr_i[g][0];
        assign cpu_if.wdata = wdata_i[g][0];
        assign rdata_o[g][0] = cpu_if.rdata;
        assign ack_o[g][0]   = cpu_if.ack;
        assign pnl_if.req   = req_i[g][1];
        assign pnl_if.we    = we_i[g][1];
        assign pnl_if.addr  = addr_i[g][1];
        assign pnl_if.wdata = wdata_i[g][1];
        assign rdata_o[g][1] = pnl_if.rdata;
        assign ack_o[g][1]   = pnl_if.ack;

        mem_arbiter #(.WAIT_CYCLES(g + 2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cpu       (cpu_if),
            .pnl       (pnl_if),
            .pnl_en    (pnl_en_i[g]),
            .mem_addr  (mem_addr_o[g]),
            .mem_wdata (mem_wdata_o[g]),
            .mem_rdata (mem_rdata_i[g]),
            .mem_read  (mem_read_o[g]),
            .mem_write (mem_write_o[g]),
            .busy      (busy_o[g]),
            .owner     (owner_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an access occupies ages 1..W (strobes) and W+1 (ack)
    bit                m_act   [2];
    int                m_age   [2];
    bit                m_own   [2];
    bit                m_we    [2];
    bit                m_last  [2];
    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [DATA_W-1:0] m_rdata [2][2];

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_rd   [2];
    int cnt_wr   [2];
    int cnt_busy [2];
    int cnt_ack  [2][2];
    bit ack_who  [2][8];
    int n_ack    [2];
    bit prev_ack [2];
    bit hold     [2][2];

    function automatic int w_of(input int d);
        return d + 2;
    endfunction

    function automatic bit exp_ack(input int d, input int p);
        return m_act[d] && (m_age[d] == w_of(d) + 1) && (int'(m_own[d]) == p);
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // Advance the model across the coming edge using the inputs now driven
    task automatic model_step(input int d);
        bit e0, e1, win;
        if (rst) begin
            m_act[d]   = 1'b0;
            m_age[d]   = 0;
            m_own[d]   = 1'b0;
            m_we[d]    = 1'b0;
            m_last[d]  = 1'b1;
            m_addr[d]  = '0;
            m_wdata[d] = '0;
            m_rdata[d][0] = '0;
            m_rdata[d][1] = '0;
        end else if (m_act[d]) begin
            if (m_age[d] == w_of(d) && !m_we[d]) m_rdata[d][m_own[d]] = mem_rdata_i[d];
            if (m_age[d] == w_of(d) + 1) m_act[d] = 1'b0;
            else                         m_age[d]++;
        end else begin
            e0 = req_i[d][0];
            e1 = req_i[d][1] && pnl_en_i[d];
            if (e0 || e1) begin
                win        = (e0 && e1) ? !m_last[d] : e1;
                m_last[d]  = win;
                m_own[d]   = win;
                m_act[d]   = 1'b1;
                m_age[d]   = 1;
                m_we[d]    = we_i[d][win];
                m_addr[d]  = addr_i[d][win];
                m_wdata[d] = wdata_i[d][win];
            end
        end
    endtask

    task automatic check_dut(input int d);
        bit strobe;
        strobe = m_act[d] && (m_age[d] <= w_of(d));
        chk("mem_read",  d, 32'(mem_read_o[d]),  32'(strobe && !m_we[d]));
        chk("mem_write", d, 32'(mem_write_o[d]), 32'(strobe && m_we[d]));
        chk("busy",      d, 32'(busy_o[d]),      32'(m_act[d]));
        chk("owner",     d, 32'(owner_o[d]),     32'(m_own[d]));
        chk("mem_addr",  d, 32'(mem_addr_o[d]),  32'(m_addr[d]));
        chk("mem_wdata", d, 32'(mem_wdata_o[d]), 32'(m_wdata[d]));
        for (int p = 0; p < 2; p++) begin
            chk(p == 1 ? "pnl_ack" : "cpu_ack",     d, 32'(ack_o[d][p]),   32'(exp_ack(d, p)));
            chk(p == 1 ? "pnl_rdata" : "cpu_rdata", d, 32'(rdata_o[d][p]), 32'(m_rdata[d][p]));
        end
        if (prev_ack[d]) chk("idle_after_ack", d, 32'(busy_o[d]), 32'd0);
    endtask

    // One clock: predict, step, sample #1 after the edge, check, let requesters drop on ack
    task automatic tick();
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_dut(d);
            if (mem_read_o[d])  cnt_rd[d]++;
            if (mem_write_o[d]) cnt_wr[d]++;
            if (busy_o[d])      cnt_busy[d]++;
            prev_ack[d] = ack_o[d][0] || ack_o[d][1];
            for (int p = 0; p < 2; p++) begin
                if (ack_o[d][p]) begin
                    if (n_ack[d] < 8) ack_who[d][n_ack[d]] = 1'(p);
                    n_ack[d]++;
                    cnt_ack[d][p]++;
                end
                if (exp_ack(d, p) && !hold[d][p]) req_i[d][p] = 1'b0;
            end
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            cnt_rd[d] = 0; cnt_wr[d] = 0; cnt_busy[d] = 0; n_ack[d] = 0;
            cnt_ack[d][0] = 0; cnt_ack[d][1] = 0;
        end
    endtask

    task automatic issue(input int p, input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
        for (int d = 0; d < 2; d++) begin
            req_i[d][p] = 1'b1; we_i[d][p] = we; addr_i[d][p] = addr; wdata_i[d][p] = wdata;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || req_i[0][0] || req_i[0][1] ||
                req_i[1][0] || req_i[1][1]) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 0, 32'(n < budget), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            pnl_en_i[d] = 1'b0; mem_rdata_i[d] = '0; prev_ack[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req_i[d][p] = 1'b0; we_i[d][p] = 1'b0; addr_i[d][p] = '0;
                wdata_i[d][p] = '0; hold[d][p] = 1'b0;
            end
        end
        clear_counts();

        // Reset
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, 32'(busy_o[d]), 32'd0);
            chk("rst_owner", d, 32'(owner_o[d]), 32'd0);
        end
        rst = 1'b0;

        // Single CPU read of 0x0010 returning 0xA5
        clear_counts();
        mem_rdata_i[0] = 8'hA5; mem_rdata_i[1] = 8'hA5;
        issue(0, 1'b0, 16'h0010, 8'h00);
        tick();
        chk("t1_read_k1", 0, 32'(mem_read_o[0]), 32'd1);
        tick();
        chk("t1_read_k2", 0, 32'(mem_read_o[0]), 32'd1);
        chk("t1_noack_k2", 0, 32'(ack_o[0][0]), 32'd0);
        tick();
        chk("t1_read_k3", 0, 32'(mem_read_o[0]), 32'd0);
        chk("t1_ack_k3", 0, 32'(ack_o[0][0]), 32'd1);
        chk("t1_rdata_k3", 0, 32'(rdata_o[0][0]), 32'h0A5);
        run_until_idle(50);
        for (int d = 0; d < 2; d++) begin
            chk("t1_read_cycles", d, 32'(cnt_rd[d]), 32'(w_of(d)));
            chk("t1_cpu_acks", d, 32'(cnt_ack[d][0]), 32'd1);
            chk("t1_pnl_acks", d, 32'(cnt_ack[d][1]), 32'd0);
            chk("t1_rdata", d, 32'(rdata_o[d][0]), 32'h0A5);
        end

        // Panel write of 0x3C to 0x0003
        clear_counts();
        pnl_en_i[0] = 1'b1; pnl_en_i[1] = 1'b1;
        issue(1, 1'b1, 16'h0003, 8'h3C);
        run_until_idle(50);
        for (int d = 0; d < 2; d++) begin
            chk("t2_write_cycles", d, 32'(cnt_wr[d]), 32'(w_of(d)));
            chk("t2_read_cycles", d, 32'(cnt_rd[d]), 32'd0);
            chk("t2_pnl_acks", d, 32'(cnt_ack[d][1]), 32'd1);
            chk("t2_owner", d, 32'(owner_o[d]), 32'd1);
            chk("t2_mem_addr", d, 32'(mem_addr_o[d]), 32'h0003);
            chk("t2_mem_wdata", d, 32'(mem_wdata_o[d]), 32'h003C);
        end

        // Panel request with pnl_en low is ignored
        clear_counts();
        pnl_en_i[0] = 1'b0; pnl_en_i[1] = 1'b0;
        hold[0][1] = 1'b1; hold[1][1] = 1'b1;
        issue(1, 1'b0, 16'h0100, 8'h00);
        repeat (20) tick();
        for (int d = 0; d < 2; d++) begin
            chk("t3_strobes", d, 32'(cnt_rd[d] + cnt_wr[d]), 32'd0);
            chk("t3_busy", d, 32'(cnt_busy[d]), 32'd0);
            chk("t3_acks", d, 32'(cnt_ack[d][0] + cnt_ack[d][1]), 32'd0);
            req_i[d][1] = 1'b0; hold[d][1] = 1'b0;
        end

        // Both requests held continuously from reset: CPU, panel, CPU
        rst = 1'b1;
        pnl_en_i[0] = 1'b1; pnl_en_i[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin hold[d][0] = 1'b1; hold[d][1] = 1'b1; end
        issue(0, 1'b0, 16'h0020, 8'h00);
        issue(1, 1'b1, 16'h0021, 8'h77);
        tick();
        rst = 1'b0;
        clear_counts();
        repeat (16) tick();
        for (int d = 0; d < 2; d++) begin
            chk("t4_ack_count", d, 32'(n_ack[d] >= 3), 32'd1);
            chk("t4_grant0", d, 32'(ack_who[d][0]), 32'd0);
            chk("t4_grant1", d, 32'(ack_who[d][1]), 32'd1);
            chk("t4_grant2", d, 32'(ack_who[d][2]), 32'd0);
            hold[d][0] = 1'b0; hold[d][1] = 1'b0;
        end
        run_until_idle(60);

        // Reset in the second ACCESS cycle aborts without an ack
        mem_rdata_i[0] = 8'h5A; mem_rdata_i[1] = 8'h5A;
        issue(0, 1'b0, 16'h0055, 8'h00);
        tick();
        tick();
        chk("t5_access2", 1, 32'(mem_read_o[1]), 32'd1);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) req_i[d][0] = 1'b0;
        tick();
        chk("t5_read", 1, 32'(mem_read_o[1]), 32'd0);
        chk("t5_write", 1, 32'(mem_write_o[1]), 32'd0);
        chk("t5_busy", 1, 32'(busy_o[1]), 32'd0);
        chk("t5_ack", 1, 32'(ack_o[1][0]), 32'd0);
        chk("t5_addr", 1, 32'(mem_addr_o[1]), 32'd0);
        chk("t5_wdata", 1, 32'(mem_wdata_o[1]), 32'd0);
        chk("t5_rdata", 1, 32'(rdata_o[1][0]), 32'd0);
        rst = 1'b0;
        clear_counts();
        repeat (10) tick();
        for (int d = 0; d < 2; d++) chk("t5_no_ack", d, 32'(cnt_ack[d][0]), 32'd0);

        // CPU drops its request in the first ACCESS cycle
        clear_counts();
        issue(0, 1'b1, 16'h0077, 8'hC3);
        tick();
        for (int d = 0; d < 2; d++) req_i[d][0] = 1'b0;
        run_until_idle(50);
        for (int d = 0; d < 2; d++) begin
            chk("t6_cpu_acks", d, 32'(cnt_ack[d][0]), 32'd1);
            chk("t6_write_cycles", d, 32'(cnt_wr[d]), 32'(w_of(d)));
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 15) == 0) pnl_en_i[d] = ~pnl_en_i[d];
                mem_rdata_i[d] = DATA_W'($urandom);
                for (int p = 0; p < 2; p++) begin
                    if (!req_i[d][p] && $urandom_range(0, 3) == 0) begin
                        req_i[d][p]   = 1'b1;
                        we_i[d][p]    = 1'($urandom);
                        addr_i[d][p]  = ADDR_W'($urandom);
                        wdata_i[d][p] = DATA_W'($urandom);
                    end
                end
            end
            tick();
        end
        rst = 1'b0;
        pnl_en_i[0] = 1'b1; pnl_en_i[1] = 1'b1;
        run_until_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
